// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Brief    : Shared direction encodings and load-clamp helper for the counter.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range load values are pulled down to the top of the count range.
    function automatic logic [63:0] clamp_load(input logic [63:0] val, input logic [63:0] mod);
        return (val >= mod) ? (mod - 64'd1) : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : param_updown_counter
//  Brief    : WIDTH-bit modulo-MOD up/down counter with enable, synchronous
//             load and registered terminal-count pulse. Define COUNTER_SAT_EN
//             to saturate at the limits instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 2,
    parameter longint unsigned MOD     = 64'd1 << WIDTH,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH:0]   MOD_M1  = (WIDTH+1)'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

`ifdef COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] DN_LIMIT_NEXT = '0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT = '0;
    localparam logic [WIDTH-1:0] DN_LIMIT_NEXT = WIDTH'(MOD - 64'd1);
`endif

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("param_updown_counter: WIDTH out of range 1..32");
        end
        if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
            $error("param_updown_counter: MOD out of range 2..2**WIDTH");
        end
        if (RST_VAL >= MOD) begin : g_bad_rst_val
            $error("param_updown_counter: RST_VAL must be below MOD");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q,  tc_d;
    logic [WIDTH:0]   cnt_ext;

    assign cnt_ext = {1'b0, cnt_q};

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = WIDTH'(clamp_load(64'(load_val), MOD));
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                // Compare against MOD-1, not the all-ones value, so short moduli wrap early.
                if (cnt_ext == MOD_M1) begin
                    cnt_d = UP_LIMIT_NEXT;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = WIDTH'(cnt_ext + (WIDTH+1)'(1));
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = DN_LIMIT_NEXT;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = WIDTH'(cnt_ext - (WIDTH+1)'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RST_CNT;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_updown_counter
//  Brief    : Scoreboard bench driving three counter configurations in lockstep
//             (2-bit mod 4, 3-bit mod 5, 2-bit mod 3) against a modular model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] cnt;
        logic [2:0] tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_val = '0;
    logic [1:0] cnt_a, cnt_c;
    logic [2:0] cnt_b;
    logic       tc_a, tc_b, tc_c;

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];

    int mods[3]  = '{4, 5, 3};
    int wids[3]  = '{2, 3, 2};
    int m_cnt[3] = '{0, 0, 0};

    always #10 clk = ~clk;

    param_updown_counter #(.WIDTH(2), .MOD(4), .RST_VAL(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[1:0]), .cnt(cnt_a), .tc(tc_a));

    param_updown_counter #(.WIDTH(3), .MOD(5), .RST_VAL(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt(cnt_b), .tc(tc_b));

    param_updown_counter #(.WIDTH(2), .MOD(3), .RST_VAL(0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[1:0]), .cnt(cnt_c), .tc(tc_c));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int act_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic int act_tc(input int i);
        case (i)
            0:       return int'(tc_a);
            1:       return int'(tc_b);
            default: return int'(tc_c);
        endcase
    endfunction

    // Drive one cycle at the falling edge and queue what each counter should show after the next rise.
    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [2:0] lv);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; up_dn = u; load = l; load_val = lv;
        x = '0;
        for (int i = 0; i < 3; i++) begin
            int m, v, t;
            m = mods[i];
            t = 0;
            v = int'(lv) % (1 << wids[i]);
            if (!r) begin
                m_cnt[i] = 0;
            end else if (l) begin
                m_cnt[i] = (v >= m) ? m - 1 : v;
            end else if (e && u) begin
                t = (m_cnt[i] == m - 1) ? 1 : 0;
                m_cnt[i] = (t == 1 && SAT) ? m_cnt[i] : (m_cnt[i] + 1) % m;
            end else if (e) begin
                t = (m_cnt[i] == 0) ? 1 : 0;
                m_cnt[i] = (t == 1 && SAT) ? m_cnt[i] : (m_cnt[i] + m - 1) % m;
            end
            x.cnt[i*3 +: 3] = 3'(m_cnt[i]);
            x.tc[i]         = t[0];
        end
        sb_q.push_back(x);
    endtask

    // Monitor: counters present a new output every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("cnt%0d", i), act_cnt(i), int'(x.cnt[i*3 +: 3]));
                    check($sformatf("tc%0d", i), act_tc(i), int'(x.tc[i]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_cnt%0d", i), act_cnt(i), 0);
            check($sformatf("rst_tc%0d", i), act_tc(i), 0);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        repeat (8) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Wrap both ways through zero.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        repeat (6) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        // Load beats enable; value 3 clamps on the mod-3 counter.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Asynchronous reset between edges at count 2.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
        @(posedge clk);
        #5;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            check($sformatf("async_cnt%0d", i), act_cnt(i), 0);
            check($sformatf("async_tc%0d", i), act_tc(i), 0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Long run up from zero then down from zero to hit the limits.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        repeat (6) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 60) != 0, ($urandom % 4) != 0, 1'($urandom % 2),
                  ($urandom % 8) == 0, 3'($urandom % 8));
        end
        @(posedge clk);
        #3;
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
